// File: rtl/streaming_slot_result_collector_pkg.sv
// Shared constants and helpers for the slot result collector.
// Optional build macro SLOT_PARITY_EN enables per-slot parity storage in the top level.
package streaming_slot_result_collector_pkg;

  localparam int ERROR_COUNT_WIDTH    = 16;
  localparam int DEF_ADDR_WIDTH       = 9;
  localparam int DEF_RESULT_WIDTH     = 6;
  localparam int DEF_EXTRA_DATA_WIDTH = 1;
  localparam int DEF_NUM_CHANNELS     = 2;
  localparam int DEF_SLOWDOWN_MARGIN  = 50;

  // Even parity over a zero-extended payload.
  function automatic logic evenParity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/streaming_slot_result_collector_if.sv
// Result return bus: one valid/ready pair per channel with packed slot tags and data.
interface streaming_slot_result_collector_if
  import streaming_slot_result_collector_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH
);
  logic [NUM_CHANNELS-1:0]              resValid;
  logic [NUM_CHANNELS-1:0]              resReady;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   resSlot;
  logic [NUM_CHANNELS*RESULT_WIDTH-1:0] resData;

  modport master (output resValid, resSlot, resData, input resReady);
  modport slave  (input resValid, resSlot, resData, output resReady);
endinterface

// File: rtl/streaming_slot_result_collector_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
module round_robin_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptrNext_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // Grant search starting at the pointer, wrapping over all requesters.
  always_comb begin
    gnt       = '0;
    ptrNext_s = ptr_r;
    idx_s     = '0;
    found_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_s = PW'((int'(ptr_r) + i) % N);
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
        ptrNext_s  = PW'((int'(idx_s) + 1) % N);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= ptrNext_s;
    end
  end
endmodule

// File: rtl/streaming_slot_result_collector.sv
// Slot-indexed result collector: tags inputs with a free-running slot and retires each slot DEPTH cycles later.
// Define SLOT_PARITY_EN to store parity per slot and add the parityError output.
module streaming_slot_result_collector
  import streaming_slot_result_collector_pkg::*;
#(
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int RESULT_WIDTH     = DEF_RESULT_WIDTH,
  parameter int EXTRA_DATA_WIDTH = DEF_EXTRA_DATA_WIDTH,
  parameter int NUM_CHANNELS     = DEF_NUM_CHANNELS,
  parameter int SLOWDOWN_MARGIN  = DEF_SLOWDOWN_MARGIN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         isBotValid,
  input  logic [EXTRA_DATA_WIDTH-1:0]  extraDataIn,
  output logic [ADDR_WIDTH-1:0]        issueSlot,
  output logic                         slowDownInput,
  streaming_slot_result_collector_if.slave res,
  output logic                         resultValid,
  output logic [RESULT_WIDTH-1:0]      resultOut,
  output logic [EXTRA_DATA_WIDTH-1:0]  extraDataOut,
  output logic                         resultMissing,
  output logic [ERROR_COUNT_WIDTH-1:0] missingCount,
  output logic [ERROR_COUNT_WIDTH-1:0] lateCount
`ifdef SLOT_PARITY_EN
  ,
  output logic                         parityError
`endif
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ERROR_COUNT_WIDTH;
  localparam logic [ADDR_WIDTH:0] SLOW_TH = (ADDR_WIDTH+1)'(DEPTH - SLOWDOWN_MARGIN);

  logic [ADDR_WIDTH-1:0]       issueSlot_r;
  logic [DEPTH-1:0]            pending_r;
  logic [DEPTH-1:0]            done_r;
  logic [ADDR_WIDTH:0]         pendingCount_r;
  logic [ADDR_WIDTH:0]         pendingNext_s;
  logic                        slowDown_r;
  logic                        resultValid_r;
  logic                        resultMissing_r;
  logic [RESULT_WIDTH-1:0]     resultOut_r;
  logic [EXTRA_DATA_WIDTH-1:0] extraDataOut_r;
  logic [CW-1:0]               missingCount_r;
  logic [CW-1:0]               lateCount_r;
  logic [RESULT_WIDTH-1:0]     resMem_r   [DEPTH];
  logic [EXTRA_DATA_WIDTH-1:0] extraMem_r [DEPTH];

  logic [NUM_CHANNELS-1:0] gnt_s;
  logic [ADDR_WIDTH-1:0]   accSlot_s;
  logic [RESULT_WIDTH-1:0] accData_s;
  logic                    accept_s;
  logic                    accWrite_s;
  logic                    accLate_s;
  logic                    retirePending_s;
  logic                    retireDone_s;

  round_robin_arbiter #(.N(NUM_CHANNELS)) uArb (
    .clk     (clk),
    .rst     (rst),
    .req     (res.resValid),
    .advance (accept_s),
    .gnt     (gnt_s)
  );

  assign res.resReady = gnt_s;

  // Select the granted channel and classify the accepted result; t==s is late because slot s retires now.
  always_comb begin
    accSlot_s = '0;
    accData_s = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      accSlot_s = accSlot_s | (res.resSlot[c*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gnt_s[c]}});
      accData_s = accData_s | (res.resData[c*RESULT_WIDTH +: RESULT_WIDTH] & {RESULT_WIDTH{gnt_s[c]}});
    end
    accept_s        = |gnt_s;
    retirePending_s = pending_r[issueSlot_r];
    retireDone_s    = done_r[issueSlot_r];
    accWrite_s      = accept_s & pending_r[accSlot_s] & ~done_r[accSlot_s] & (accSlot_s != issueSlot_r);
    accLate_s       = accept_s & ~accWrite_s;
    pendingNext_s   = pendingCount_r + (ADDR_WIDTH+1)'(isBotValid) - (ADDR_WIDTH+1)'(retirePending_s);
  end

  // Slot state, retirement flags and error counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issueSlot_r     <= '0;
      pending_r       <= '0;
      done_r          <= '0;
      pendingCount_r  <= '0;
      slowDown_r      <= 1'b0;
      resultValid_r   <= 1'b0;
      resultMissing_r <= 1'b0;
      missingCount_r  <= '0;
      lateCount_r     <= '0;
    end else begin
      issueSlot_r            <= issueSlot_r + ADDR_WIDTH'(1);
      pending_r[issueSlot_r] <= isBotValid;
      done_r[issueSlot_r]    <= 1'b0;
      if (accWrite_s) begin
        done_r[accSlot_s] <= 1'b1;
      end
      pendingCount_r  <= pendingNext_s;
      slowDown_r      <= (pendingNext_s > SLOW_TH);
      resultValid_r   <= retirePending_s;
      resultMissing_r <= retirePending_s & ~retireDone_s;
      if (retirePending_s && !retireDone_s && (missingCount_r != {CW{1'b1}})) begin
        missingCount_r <= missingCount_r + CW'(1);
      end
      if (accLate_s && (lateCount_r != {CW{1'b1}})) begin
        lateCount_r <= lateCount_r + CW'(1);
      end
    end
  end

  // Registered read port of the slot storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resultOut_r    <= '0;
      extraDataOut_r <= '0;
    end else begin
      resultOut_r    <= retireDone_s ? resMem_r[issueSlot_r] : '0;
      extraDataOut_r <= extraMem_r[issueSlot_r];
    end
  end

  // Slot storage write ports; contents survive reset.
  always_ff @(posedge clk) begin
    if (accWrite_s) begin
      resMem_r[accSlot_s] <= accData_s;
    end
    extraMem_r[issueSlot_r] <= extraDataIn;
  end

`ifdef SLOT_PARITY_EN
  logic parMem_r   [DEPTH];
  logic parExtra_r [DEPTH];
  logic parityError_r;

  // Parity bits written alongside the slot storage.
  always_ff @(posedge clk) begin
    if (accWrite_s) begin
      parMem_r[accSlot_s] <= evenParity(32'(accData_s));
    end
    parExtra_r[issueSlot_r] <= evenParity(32'(extraDataIn));
  end

  // Parity check on the retiring slot, only when it held a valid input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parityError_r <= 1'b0;
    end else begin
      parityError_r <= retirePending_s &
        ((retireDone_s & (parMem_r[issueSlot_r] != evenParity(32'(resMem_r[issueSlot_r])))) |
         (parExtra_r[issueSlot_r] != evenParity(32'(extraMem_r[issueSlot_r]))));
    end
  end

  assign parityError = parityError_r;
`endif

  assign issueSlot     = issueSlot_r;
  assign slowDownInput = slowDown_r;
  assign resultValid   = resultValid_r;
  assign resultMissing = resultMissing_r;
  assign resultOut     = resultOut_r;
  assign extraDataOut  = extraDataOut_r;
  assign missingCount  = missingCount_r;
  assign lateCount     = lateCount_r;
endmodule

// File: tb/tb_streaming_slot_result_collector.sv
// Scoreboard bench for streaming_slot_result_collector: stimulus pushes expected retirements, a monitor pops them.
module tb_streaming_slot_result_collector;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int RW    = 6;
  localparam int NC    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          isBotValid = 1'b0;
  logic [0:0]    extraDataIn = 1'b0;
  logic [AW-1:0] issueSlot;
  logic          slowDownInput;
  logic          resultValid;
  logic [RW-1:0] resultOut;
  logic [0:0]    extraDataOut;
  logic          resultMissing;
  logic [15:0]   missingCount;
  logic [15:0]   lateCount;
`ifdef SLOT_PARITY_EN
  logic          parityError;
`endif

  streaming_slot_result_collector_if #(.NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) resIf ();

  streaming_slot_result_collector dut (
    .clk           (clk),
    .rst           (rst),
    .isBotValid    (isBotValid),
    .extraDataIn   (extraDataIn),
    .issueSlot     (issueSlot),
    .slowDownInput (slowDownInput),
    .res           (resIf),
    .resultValid   (resultValid),
    .resultOut     (resultOut),
    .extraDataOut  (extraDataOut),
    .resultMissing (resultMissing),
    .missingCount  (missingCount),
    .lateCount     (lateCount)
`ifdef SLOT_PARITY_EN
    ,
    .parityError   (parityError)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] res;
    logic       miss;
    logic       extra;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mslot = 0;
  bit   expV;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference slot counter and cycle count.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc   = 0;
      mslot = 0;
    end else begin
      cyc++;
      mslot = (mslot + 1) % DEPTH;
    end
  end

  // Monitor: compares every retirement against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("issueSlot", 32'(issueSlot), 32'(mslot));
      expV = (q.size() > 0) && (q[0].cyc == cyc);
      if (resultValid === 1'b1 || expV) begin
        chk("resultValid", 32'(resultValid), 32'(expV));
        if (expV) begin
          chk("resultOut", 32'(resultOut), 32'(q[0].res));
          chk("resultMissing", 32'(resultMissing), 32'(q[0].miss));
          chk("extraDataOut", 32'(extraDataOut), 32'(q[0].extra));
`ifdef SLOT_PARITY_EN
          chk("parityError", 32'(parityError), 32'd0);
`endif
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitSlot(input int s);
    for (int i = 0; i < DEPTH + 2 && mslot != s; i++) step();
  endtask

  task automatic issue(input logic e, input logic [5:0] r, input logic m);
    exp_t x;
    x.cyc = cyc + 1 + DEPTH;
    x.res = r;
    x.miss = m;
    x.extra = e;
    q.push_back(x);
    isBotValid  = 1'b1;
    extraDataIn = e;
    step();
    isBotValid  = 1'b0;
    extraDataIn = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 3 * DEPTH) begin
      step();
      n++;
    end
    chk("drain_remaining", 32'(q.size()), 32'd0);
  endtask

  task automatic sendRes(input int ch, input int slot, input logic [5:0] d);
    logic [AW-1:0] sl;
    logic          got;
    sl = slot[AW-1:0];
    resIf.resSlot[ch*AW +: AW] = sl;
    resIf.resData[ch*RW +: RW] = d;
    resIf.resValid[ch] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 4 && !got; n++) begin
      #1;
      got = resIf.resReady[ch];
      @(posedge clk);
      #1;
    end
    resIf.resValid[ch] = 1'b0;
    chk("sendRes_ready", 32'(got), 32'd1);
  endtask

  task automatic chkOutputsZero(input string tag);
    chk({tag, "_issueSlot"}, 32'(issueSlot), 32'd0);
    chk({tag, "_resultValid"}, 32'(resultValid), 32'd0);
    chk({tag, "_resultOut"}, 32'(resultOut), 32'd0);
    chk({tag, "_resultMissing"}, 32'(resultMissing), 32'd0);
    chk({tag, "_missingCount"}, 32'(missingCount), 32'd0);
    chk({tag, "_lateCount"}, 32'(lateCount), 32'd0);
    chk({tag, "_slowDown"}, 32'(slowDownInput), 32'd0);
  endtask

  initial begin
    logic [1:0] g;
    int h0, h1, prev, guard;
    resIf.resValid = '0;
    resIf.resSlot  = '0;
    resIf.resData  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chkOutputsZero("reset");
    chk("reset_extraDataOut", 32'(extraDataOut), 32'd0);
    chk("reset_resReady", 32'(resIf.resReady), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle for two laps; slot counter wraps 511 -> 0
    repeat (2 * DEPTH) step();
    chk("idle_missingCount", 32'(missingCount), 32'd0);
    chk("idle_lateCount", 32'(lateCount), 32'd0);
    waitSlot(511);
    chk("wrap_511", 32'(issueSlot), 32'd511);
    step();
    chk("wrap_0", 32'(issueSlot), 32'd0);

    // Single input at slot 5, channel 0 returns 17 ten cycles later
    waitSlot(5);
    issue(1'b1, 6'd17, 1'b0);
    repeat (9) step();
    sendRes(0, 5, 6'd17);
    drain();

    // Input at slot 7 with no result
    waitSlot(7);
    issue(1'b0, 6'd0, 1'b1);
    drain();
    chk("missing_count1", 32'(missingCount), 32'd1);

    // Slots 0..99, both channels valid together, grants must alternate
    waitSlot(0);
    for (int i = 0; i < 100; i++) issue(i[0], 6'((i * 3 + 1) & 63), 1'b0);
    h0 = 0; h1 = 1; prev = -1; guard = 0;
    while ((h0 < 100 || h1 < 100) && guard < 300) begin
      resIf.resValid = {h1 < 100, h0 < 100};
      resIf.resSlot[0 +: AW]  = AW'(h0);
      resIf.resData[0 +: RW]  = 6'((h0 * 3 + 1) & 63);
      resIf.resSlot[AW +: AW] = AW'(h1);
      resIf.resData[RW +: RW] = 6'((h1 * 3 + 1) & 63);
      #1;
      g = resIf.resReady;
      if (h0 < 100 && h1 < 100) begin
        chk("rr_onehot", 32'($countones(g)), 32'd1);
        if (prev >= 0) chk("rr_alternate", 32'(g), (prev == 0) ? 32'd2 : 32'd1);
      end
      if (g[1]) prev = 1;
      else if (g[0]) prev = 0;
      step();
      if (g[0]) h0 += 2;
      if (g[1]) h1 += 2;
      guard++;
    end
    resIf.resValid = '0;
    chk("rr_all_sent", 32'(guard < 300), 32'd1);
    drain();
    chk("rr_lateCount", 32'(lateCount), 32'd0);

    // Late cases: never-issued slot, duplicate, result on the retiring slot
    waitSlot(20);
    issue(1'b0, 6'd9, 1'b0);
    waitSlot(40);
    issue(1'b1, 6'd0, 1'b1);
    sendRes(0, 300, 6'd5);
    sendRes(1, 20, 6'd9);
    sendRes(0, 20, 6'd33);
    waitSlot(40);
    sendRes(1, 40, 6'd12);
    drain();
    chk("late_count3", 32'(lateCount), 32'd3);
    chk("late_missingCount", 32'(missingCount), 32'd2);

    // slowDownInput threshold: pending > 462
    waitSlot(0);
    for (int i = 0; i < 462; i++) issue(i[0], 6'd0, 1'b1);
    chk("slow_462", 32'(slowDownInput), 32'd0);
    issue(1'b1, 6'd0, 1'b1);
    chk("slow_463", 32'(slowDownInput), 32'd1);
    for (int i = 0; i < 7; i++) issue(1'b0, 6'd0, 1'b1);
    chk("slow_470", 32'(slowDownInput), 32'd1);
    drain();
    chk("slow_missingCount", 32'(missingCount), 32'd472);
    chk("slow_after_drain", 32'(slowDownInput), 32'd0);

    // Asynchronous reset mid-stream discards in-flight slots
    waitSlot(100);
    isBotValid = 1'b1;
    repeat (10) step();
    isBotValid = 1'b0;
    repeat (5) step();
    #1;
    rst = 1'b0;
    #1;
    chkOutputsZero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (DEPTH + 20) step();
    chk("post_reset_missingCount", 32'(missingCount), 32'd0);
    chk("post_reset_lateCount", 32'(lateCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
